// File: rtl/dac_pattern_pkg.sv
//==============================================================================
// Module : dac_pattern_pkg
// Brief  : Shared encodings for the DAC test-pattern generator.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package dac_pattern_pkg;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_PRBS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         PRBS_W    = 15;
    localparam logic [14:0] PRBS_SEED = 15'h7FFF;

endpackage

`default_nettype wire

// File: rtl/dac_prbs15_step.sv
//==============================================================================
// Module : dac_prbs15_step
// Brief  : Combinational STEPS-step advance of a Fibonacci PRBS15 (x^15+x^14+1).
//          bits[STEPS-1] is the earliest generated bit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dac_prbs15_step
    import dac_pattern_pkg::*;
#(
    parameter int STEPS = 64
) (
    input  logic [PRBS_W-1:0] state,
    output logic [PRBS_W-1:0] next_state,
    output logic [STEPS-1:0]  bits
);

    logic [PRBS_W-1:0] w_chain [0:STEPS];

    assign w_chain[0] = state;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        logic w_new;
        assign w_new          = w_chain[k][14] ^ w_chain[k][13];
        assign bits[STEPS-1-k] = w_new;
        assign w_chain[k+1]   = {w_chain[k][13:0], w_new};
    end

    assign next_state = w_chain[STEPS];

endmodule

`default_nettype wire

// File: rtl/dac_pattern_gen.sv
//==============================================================================
// Module : dac_pattern_gen
// Brief  : Zero/ramp/constant(/PRBS15) burst pattern source feeding the DAC
//          write-side FIFO lanes I0,Q0,I1,Q1. Mode 3 is PRBS15 only when
//          DAC_PATTERN_PRBS_EN is defined; otherwise it behaves as zero.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dac_pattern_gen
    import dac_pattern_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RAMP_STEP = 1,
    parameter int BURST_W   = 16
) (
    input  logic               wr_clk,
    input  logic               wr_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  const_i,
    input  logic [DATA_W-1:0]  const_q,
    input  logic [BURST_W-1:0] burst_len,
    output logic [DATA_W-1:0]  wr_data_0,
    output logic [DATA_W-1:0]  wr_data_1,
    output logic [DATA_W-1:0]  wr_data_2,
    output logic [DATA_W-1:0]  wr_data_3,
    output logic               wr_valid,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_mode;
    logic [DATA_W-1:0]  r_const_i;
    logic [DATA_W-1:0]  r_const_q;
    logic [BURST_W-1:0] r_burst_len;
    logic [BURST_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_base;
    logic               w_last;
    logic               w_run;
    logic [DATA_W-1:0]  w_ramp_hi;
    logic [DATA_W-1:0]  w_lane0, w_lane1, w_lane2, w_lane3;

    assign w_run     = (r_state == ST_RUN);
    assign w_last    = (r_burst_len != '0) && (r_cnt == r_burst_len - BURST_W'(1));
    assign w_ramp_hi = r_base + DATA_W'(RAMP_STEP);

`ifdef DAC_PATTERN_PRBS_EN
    logic [PRBS_W-1:0]   r_lfsr;
    logic [PRBS_W-1:0]   w_lfsr_next;
    logic [4*DATA_W-1:0] w_prbs_bits;

    dac_prbs15_step #(
        .STEPS      (4*DATA_W)
    ) u_prbs (
        .state      (r_lfsr),
        .next_state (w_lfsr_next),
        .bits       (w_prbs_bits)
    );

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_lfsr <= '0;
        end else if (r_state == ST_ARM) begin
            r_lfsr <= PRBS_SEED;
        end else if (w_run) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A stop coinciding with the last burst cycle still yields a single DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_ARM;
            ST_ARM:  w_next = ST_RUN;
            ST_RUN:  if (stop || w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_mode      <= MODE_ZERO;
            r_const_i   <= '0;
            r_const_q   <= '0;
            r_burst_len <= '0;
            r_cnt       <= '0;
            r_base      <= '0;
        end else if (r_state == ST_ARM) begin
            r_mode      <= mode;
            r_const_i   <= const_i;
            r_const_q   <= const_q;
            r_burst_len <= burst_len;
            r_cnt       <= '0;
            r_base      <= '0;
        end else if (w_run) begin
            r_cnt       <= r_cnt + BURST_W'(1);
            r_base      <= r_base + DATA_W'(2*RAMP_STEP);
        end
    end

    always_comb begin
        w_lane0 = '0;
        w_lane1 = '0;
        w_lane2 = '0;
        w_lane3 = '0;
        case (r_mode)
            MODE_RAMP: begin
                w_lane0 = r_base;
                w_lane1 = ~r_base;
                w_lane2 = w_ramp_hi;
                w_lane3 = ~w_ramp_hi;
            end
            MODE_CONST: begin
                w_lane0 = r_const_i;
                w_lane1 = r_const_q;
                w_lane2 = r_const_i;
                w_lane3 = r_const_q;
            end
`ifdef DAC_PATTERN_PRBS_EN
            MODE_PRBS: begin
                w_lane0 = w_prbs_bits[4*DATA_W-1 -: DATA_W];
                w_lane1 = w_prbs_bits[3*DATA_W-1 -: DATA_W];
                w_lane2 = w_prbs_bits[2*DATA_W-1 -: DATA_W];
                w_lane3 = w_prbs_bits[DATA_W-1   -: DATA_W];
            end
`endif
            default: begin
                w_lane0 = '0;
                w_lane1 = '0;
                w_lane2 = '0;
                w_lane3 = '0;
            end
        endcase
    end

    // Outputs trail the state by one edge so every port is a flop.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_data_0 <= '0;
            wr_data_1 <= '0;
            wr_data_2 <= '0;
            wr_data_3 <= '0;
        end else begin
            wr_valid  <= w_run;
            busy      <= (r_state != ST_IDLE);
            done      <= (r_state == ST_DONE);
            wr_data_0 <= w_run ? w_lane0 : '0;
            wr_data_1 <= w_run ? w_lane1 : '0;
            wr_data_2 <= w_run ? w_lane2 : '0;
            wr_data_3 <= w_run ? w_lane3 : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dac_pattern_gen.sv
//==============================================================================
// Module : tb_dac_pattern_gen
// Brief  : Directed self-checking bench for dac_pattern_gen.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_dac_pattern_gen;

    logic        wr_clk;
    logic        wr_rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] const_i;
    logic [15:0] const_q;
    logic [15:0] burst_len;
    logic [15:0] wr_data_0, wr_data_1, wr_data_2, wr_data_3;
    logic        wr_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    dac_pattern_gen #(
        .DATA_W    (16),
        .RAMP_STEP (1),
        .BURST_W   (16)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst_n  (wr_rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .const_i   (const_i),
        .const_q   (const_q),
        .burst_len (burst_len),
        .wr_data_0 (wr_data_0),
        .wr_data_1 (wr_data_1),
        .wr_data_2 (wr_data_2),
        .wr_data_3 (wr_data_3),
        .wr_valid  (wr_valid),
        .busy      (busy),
        .done      (done)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Checks valid/busy/done and the four lanes in one call.
    task automatic check_out(input string tag, input logic v, input logic b, input logic d,
                             input logic [63:0] lanes);
        check({tag, ".ctl"}, {61'd0, wr_valid, busy, done}, {61'd0, v, b, d});
        check({tag, ".lanes"}, {wr_data_0, wr_data_1, wr_data_2, wr_data_3}, lanes);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'd0;
        const_i   = 16'h0;
        const_q   = 16'h0;
        burst_len = 16'd0;
        wr_rst_n  = 1'b0;
        repeat (3) tick();
        wr_rst_n  = 1'b1;
        tick();
        check_out("reset", 1'b0, 1'b0, 1'b0, 64'h0);

        // Reset mid-RUN, continuous constant mode
        mode = 2'd2; const_i = 16'h5555; const_q = 16'hAAAA; burst_len = 16'd0;
        pulse_start();
        repeat (3) tick();
        check_out("pre_rst", 1'b1, 1'b1, 1'b0, 64'h5555_AAAA_5555_AAAA);
        #2 wr_rst_n = 1'b0;
        #1 check_out("async_rst", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        wr_rst_n = 1'b1;
        tick();
        check_out("post_rst0", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check_out("post_rst1", 1'b0, 1'b0, 1'b0, 64'h0);

        // Constant burst of 5
        mode = 2'd2; const_i = 16'h1234; const_q = 16'hABCD; burst_len = 16'd5;
        pulse_start();
        check_out("c_t0", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check_out("c_arm", 1'b0, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("c_run%0d", i), 1'b1, 1'b1, 1'b0, 64'h1234_ABCD_1234_ABCD);
        end
        tick();
        check_out("c_done", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();
        check_out("c_idle", 1'b0, 1'b0, 1'b0, 64'h0);

        // Continuous ramp, wrap, then stop
        mode = 2'd1; burst_len = 16'd0;
        pulse_start();
        tick();
        tick();
        check_out("r_s0", 1'b1, 1'b1, 1'b0, 64'h0000_FFFF_0001_FFFE);
        tick();
        check_out("r_s1", 1'b1, 1'b1, 1'b0, 64'h0002_FFFD_0003_FFFC);
        repeat (32766) tick();
        check_out("r_s32767", 1'b1, 1'b1, 1'b0, 64'hFFFE_0001_FFFF_0000);
        tick();
        check_out("r_wrap", 1'b1, 1'b1, 1'b0, 64'h0000_FFFF_0001_FFFE);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_out("r_last", 1'b1, 1'b1, 1'b0, 64'h0002_FFFD_0003_FFFC);
        tick();
        check_out("r_done", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();
        check_out("r_idle", 1'b0, 1'b0, 1'b0, 64'h0);

        // Ramp burst of 3: mid-burst input changes and start ignored, stop on last cycle
        mode = 2'd1; burst_len = 16'd3;
        pulse_start();
        tick();
        mode = 2'd2; const_i = 16'hDEAD; const_q = 16'hBEEF; burst_len = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("i_s0", 1'b1, 1'b1, 1'b0, 64'h0000_FFFF_0001_FFFE);
        tick();
        check_out("i_s1", 1'b1, 1'b1, 1'b0, 64'h0002_FFFD_0003_FFFC);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_out("i_s2", 1'b1, 1'b1, 1'b0, 64'h0004_FFFB_0005_FFFA);
        tick();
        check_out("i_done", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();
        check_out("i_idle", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check_out("i_idle2", 1'b0, 1'b0, 1'b0, 64'h0);

        // Zero mode, single-cycle burst, start held for 4 cycles
        mode = 2'd0; const_i = 16'h7777; const_q = 16'h8888; burst_len = 16'd1;
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        check_out("z_done", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();
        check_out("z_idle", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check_out("z_idle2", 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check_out("z_idle3", 1'b0, 1'b0, 1'b0, 64'h0);

        // Zero mode again with explicit sampling of the single valid cycle
        burst_len = 16'd1;
        pulse_start();
        tick();
        tick();
        check_out("z_s0", 1'b1, 1'b1, 1'b0, 64'h0);
        tick();
        check_out("z_done2", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();

        // Mode 3
        mode = 2'd3; burst_len = 16'd4;
        pulse_start();
        tick();
`ifdef DAC_PATTERN_PRBS_EN
        begin
            logic [14:0] s;
            logic [63:0] w;
            logic        nb;
            s = 15'h7FFF;
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 64; b++) begin
                    nb       = s[14] ^ s[13];
                    w[63-b]  = nb;
                    s        = {s[13:0], nb};
                end
                tick();
                check_out($sformatf("p_s%0d", k), 1'b1, 1'b1, 1'b0, w);
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out($sformatf("p_s%0d", k), 1'b1, 1'b1, 1'b0, 64'h0);
        end
`endif
        tick();
        check_out("p_done", 1'b0, 1'b1, 1'b1, 64'h0);
        tick();
        check_out("p_idle", 1'b0, 1'b0, 1'b0, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dac_pattern_gen.md
Name: dac_pattern_gen

Overview:
- Single-clock DAC test-pattern source in the write-clock domain.
- Directly upstream of the DAC clock-domain-crossing FIFO stage: drives its four 16-bit write lanes (I0, Q0, I1, Q1) and a write-valid.
- Produces zero, ramp or constant patterns, in fixed-length bursts or continuously, under start/stop control from the control plane.

Parameters:
- DATA_W, 16, sample width per lane.
- RAMP_STEP, 1, ramp increment per lane position; the ramp base advances 2*RAMP_STEP per valid cycle.
- BURST_W, 16, width of the burst-length field and the burst counter.

Ports:
- wr_clk  in  1  sole clock.
- wr_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; honoured only in IDLE.
- stop  in  1  level/pulse; ends RUN early.
- mode  in  2  0=zero, 1=ramp, 2=constant, 3=PRBS (feature-dependent).
- const_i  in  DATA_W  constant-mode I value.
- const_q  in  DATA_W  constant-mode Q value.
- burst_len  in  BURST_W  valid cycles per burst; 0 = continuous.
- wr_data_0..wr_data_3  out  DATA_W each  lane samples I0, Q0, I1, Q1.
- wr_valid  out  1  samples valid this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of burst or after stop.

Behaviour:
- Reset (wr_rst_n low, asynchronous): state=IDLE; all outputs 0; internal counters, ramp base and LFSR cleared.
- Release of reset is synchronous to wr_clk.
- All outputs are registered. When wr_valid=0, all wr_data_* = 0.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE -> ARM: start=1. Start in any other state is ignored.
- ARM (exactly 1 cycle):
  - latch mode, const_i, const_q, burst_len;
  - clear burst counter and ramp base; seed LFSR;
  - unconditional transition to RUN.
- RUN:
  - wr_valid=1 every cycle.
  - Latency: start sampled at edge t gives the first valid sample after edge t+2.
  - Burst counter increments each RUN cycle.
  - If latched burst_len != 0 and counter == burst_len-1, this is the last valid cycle; next state DONE.
  - If burst_len == 0, RUN continues until stop.
- stop=1 in RUN: the current cycle's sample is still valid; next state DONE. Stop in IDLE/ARM/DONE is ignored.
- Last-cycle tie: stop coinciding with the last burst cycle gives one DONE, not two.
- DONE (1 cycle): wr_valid=0, done=1, busy=1; then IDLE.
- Input changes during ARM/RUN/DONE have no effect until the next ARM.
- Mode 0 (zero): all lanes 0, with wr_valid still 1.
- Mode 1 (ramp), with r = base:
  - lane0 = r; lane1 = ~r; lane2 = r+RAMP_STEP; lane3 = ~(r+RAMP_STEP).
  - base advances by 2*RAMP_STEP each valid cycle.
  - All arithmetic is modulo 2^DATA_W; wrap is silent.
- Mode 2 (constant): lane0 = lane2 = const_i; lane1 = lane3 = const_q.
- Mode 3: see Optional Feature.
- Reset mid-RUN: immediate return to IDLE with outputs 0; no done pulse.

Optional Feature:
- Macro: DAC_PATTERN_PRBS_EN.
- Defined: mode 3 = PRBS15.
  - Polynomial x^15+x^14+1, Fibonacci form, new bit = s[14]^s[13] shifted in at s[0].
  - Seeded 15'h7FFF in ARM.
  - Advances 4*DATA_W steps per valid cycle.
  - Lane k carries generated bits 16k..16k+15; the earliest bit goes to the MSB of lane 0.
- Undefined: no LFSR logic; mode 3 behaves exactly as mode 0.

Decomposition:
- Shared package dac_pattern_pkg holds:
  - mode encodings (MODE_ZERO, MODE_RAMP, MODE_CONST, MODE_PRBS);
  - FSM state encodings;
  - PRBS seed constant.
- One sub-module, dac_prbs15_step: combinational N-step LFSR advance, returning next state and 64 output bits.
- Instantiated only under DAC_PATTERN_PRBS_EN.

Test Plan:
1. Reset mid-RUN: assert wr_rst_n=0 asynchronously -> all outputs 0 before the next edge; no done; state IDLE; next start yields a normal burst.
2. mode=2, const_i=16'h1234, const_q=16'hABCD, burst_len=5, start at t -> wr_valid high edges t+2..t+6, lanes 1234/ABCD/1234/ABCD, done at t+7, busy low at t+8.
3. mode=1, RAMP_STEP=1, burst_len=0 -> cycle0 lanes 0000/FFFF/0001/FFFE, cycle1 0002/FFFD/0003/FFFC; after 32768 cycles base wraps to 0000; stop -> exactly one more valid sample, then a done pulse.
4. start during RUN, and mode/const changes mid-burst -> ignored; burst length and pattern unchanged. stop on the final cycle of burst_len=3 -> exactly 3 valid cycles, single done.
5. mode=0, burst_len=1 -> one valid cycle of all-zero lanes, done the next cycle. start held high for 4 cycles -> only one burst.
6. With DAC_PATTERN_PRBS_EN: mode=3, burst_len=4 -> 256 output bits match the software PRBS15 model seeded 7FFF. Without the macro: mode=3 gives zeros with valid.
